// File: rtl/memory_map_pkg.sv
// ---------------------------------------------------------------------------
// memory_map_pkg
// Shared memory-map constants and the pixel reader state encoding. The
// memory controller imports this package too, so the RAM window limits are
// defined here once.
//   RAM_BASE       : first word of the result-pixel region
//   RAM_END        : first word past the end of the RAM window
//   reader_state_t : pixel_stream_reader FSM states
// ---------------------------------------------------------------------------
package memory_map_pkg;

    localparam int unsigned RAM_BASE = 90400;
    localparam int unsigned RAM_END  = 220000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SEND,
        FINISH
    } reader_state_t;

endpackage

// File: rtl/pixel_stream_reader.sv
// ---------------------------------------------------------------------------
// pixel_stream_reader
// Streams one frame of NUM_WORDS words out of the memory controller, starting
// at BASE_ADDR. Each word is fetched, the low byte is kept as a pixel, and the
// pixel is offered on a valid/ready port. Words are fetched one at a time, so
// each pixel takes READ_LATENCY+2 cycles when the sink never stalls.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   reset        : synchronous active-high reset, wins over start
//   start        : one-cycle frame request, ignored unless idle
//   mem_address  : word address to the memory controller (0 when idle)
//   mem_rd       : read data, valid READ_LATENCY cycles after the address
//   out_data     : pixel byte, mem_rd[7:0] of the fetched word
//   out_valid    : out_data holds a pixel waiting for the sink
//   out_ready    : sink accepts out_data this cycle
//   busy         : high from the start acceptance through the done cycle
//   done         : one-cycle pulse after the last pixel is accepted
// ---------------------------------------------------------------------------
module pixel_stream_reader
    import memory_map_pkg::*;
#(
    parameter int unsigned BASE_ADDR    = RAM_BASE,
    parameter int unsigned NUM_WORDS    = 90000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_rd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    // The frame must stay inside the RAM window and the latency must fit
    // the 3-bit counter.
    if (BASE_ADDR + NUM_WORDS > RAM_END) begin : g_bad_range
        $error("pixel_stream_reader: BASE_ADDR+NUM_WORDS-1 exceeds RAM_END-1");
    end
    if (NUM_WORDS == 0 || NUM_WORDS > 129600) begin : g_bad_words
        $error("pixel_stream_reader: NUM_WORDS must be 1..129600");
    end
    if (READ_LATENCY == 0 || READ_LATENCY > 4) begin : g_bad_latency
        $error("pixel_stream_reader: READ_LATENCY must be 1..4");
    end

    localparam logic [2:0]  LAT_LAST   = 3'(READ_LATENCY - 1);
    localparam logic [31:0] LAST_INDEX = 32'(NUM_WORDS - 1);

    reader_state_t state;
    reader_state_t next_state;
    logic [31:0]   index;
    logic [2:0]    lat_cnt;

    // Only the low byte of each word carries a pixel.
    logic unused_rd_bits;
    assign unused_rd_bits = ^mem_rd[31:8];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. WAIT covers READ_LATENCY cycles: the address went out
    // in ISSUE, so the word is on mem_rd during the final WAIT cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (lat_cnt == LAT_LAST) next_state = SEND;
            SEND: begin
                if (out_ready) begin
                    next_state = (index == LAST_INDEX) ? FINISH : ISSUE;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers. The word index advances only on a handshake, and
    // not past the last word, so the final address stays put during FINISH.
    always_ff @(posedge clk) begin
        if (reset) begin
            index    <= '0;
            lat_cnt  <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) index <= '0;
                end
                ISSUE: begin
                    lat_cnt <= '0;
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        out_data <= mem_rd[7:0];
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                SEND: begin
                    if (out_ready && (index != LAST_INDEX)) begin
                        index <= index + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode directly from the state. The address is held from ISSUE
    // until the pixel is handed off.
    always_comb begin
        mem_address = '0;
        out_valid   = 1'b0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            ISSUE, WAIT: mem_address = BASE_ADDR + index;
            SEND: begin
                mem_address = BASE_ADDR + index;
                out_valid   = 1'b1;
            end
            FINISH:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pixel_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_pixel_stream_reader
// Three readers share one clock and reset: a 4-word frame with latency 1, a
// 4-word frame with latency 3 behind a 3-stage memory pipeline, and a 1-word
// frame. Expected pixels are queued when a frame is started and popped on
// each accepted handshake.
// ---------------------------------------------------------------------------
module tb_pixel_stream_reader;
    import memory_map_pkg::*;

    localparam int unsigned BASE = RAM_BASE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  start_v;
    logic        ready;

    logic [31:0] addr_a, addr_b, addr_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic [7:0]  data_a, data_b, data_c;
    logic        valid_a, valid_b, valid_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    pixel_stream_reader #(.BASE_ADDR(BASE), .NUM_WORDS(4), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .mem_address(addr_a),
        .mem_rd(rd_a), .out_data(data_a), .out_valid(valid_a), .out_ready(ready),
        .busy(busy_a), .done(done_a)
    );

    pixel_stream_reader #(.BASE_ADDR(BASE), .NUM_WORDS(4), .READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .mem_address(addr_b),
        .mem_rd(rd_b), .out_data(data_b), .out_valid(valid_b), .out_ready(ready),
        .busy(busy_b), .done(done_b)
    );

    pixel_stream_reader #(.BASE_ADDR(BASE), .NUM_WORDS(1), .READ_LATENCY(1)) dut_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .mem_address(addr_c),
        .mem_rd(rd_c), .out_data(data_c), .out_valid(valid_c), .out_ready(ready),
        .busy(busy_c), .done(done_c)
    );

    // Memory models: registered reads returning address&0xFF in the low byte
    // and junk in the upper bytes, which the reader must drop.
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        rd_a      <= {24'hC0FFEE, addr_a[7:0]};
        rd_c      <= {24'hBADBAD, addr_c[7:0]};
        pipe_b[0] <= {24'h5A5A5A, addr_b[7:0]};
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rd_b = pipe_b[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          sel = 0;
    logic [31:0] obs_addr;
    logic [7:0]  obs_data;
    logic        obs_valid, obs_busy, obs_done;
    always_comb begin
        case (sel)
            0: begin
                obs_addr = addr_a; obs_data = data_a; obs_valid = valid_a;
                obs_busy = busy_a; obs_done = done_a;
            end
            1: begin
                obs_addr = addr_b; obs_data = data_b; obs_valid = valid_b;
                obs_busy = busy_b; obs_done = done_b;
            end
            default: begin
                obs_addr = addr_c; obs_data = data_c; obs_valid = valid_c;
                obs_busy = busy_c; obs_done = done_c;
            end
        endcase
    end

    int         compared = 0;
    int         mismatched = 0;
    logic [7:0] sb [$];

    task automatic push_frame(input int n);
        sb.delete();
        for (int i = 0; i < n; i++) sb.push_back(8'((BASE + 32'(i)) & 32'hFF));
    endtask

    // Reset together with start on every instance: all outputs must be clear.
    task automatic test_reset();
        reset = 1'b1; start_v = 3'b111; ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            compared++;
            if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_done !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_ctrl[%0d]: busy=%b valid=%b done=%b required 0 0 0",
                         s, obs_busy, obs_valid, obs_done);
            end
            compared++;
            if (obs_addr !== 32'd0 || obs_data !== 8'd0) begin
                mismatched++;
                $display("[TB] FAIL reset_data[%0d]: addr=%0h data=%0h required 0 0",
                         s, obs_addr, obs_data);
            end
        end
        start_v = 3'b000;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
    endtask

    // Full 4-pixel frame with the sink always ready.
    task automatic test_basic();
        int t0, donecyc, ndone, acc, lasths;
        logic prevdone;
        logic [7:0] exp;
        sel = 0; @(negedge clk); #1;
        push_frame(4);
        ready = 1'b1; start_v = 3'b001; t0 = cyc;
        ndone = 0; acc = 0; lasths = -1; donecyc = -1; prevdone = 1'b0;
        @(negedge clk); start_v = 3'b000;
        compared++;
        if (obs_addr !== BASE || obs_busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_issue: addr=%0h busy=%b required %0h 1", obs_addr, obs_busy, BASE);
        end
        for (int k = 0; k < 25; k++) begin
            if (obs_valid && ready) begin
                acc++;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL basic_extra: pixel %0h with nothing expected", obs_data);
                end else begin
                    exp = sb.pop_front();
                    if (obs_data !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL basic_data: got %0h required %0h", obs_data, exp);
                    end
                end
                if (lasths >= 0) begin
                    compared++;
                    if (cyc - lasths != 3) begin
                        mismatched++;
                        $display("[TB] FAIL basic_spacing: %0d cycles required 3", cyc - lasths);
                    end
                end
                lasths = cyc;
            end
            if (prevdone) begin
                compared++;
                if (obs_busy !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL basic_busy_drop: busy=%b required 0", obs_busy);
                end
            end
            prevdone = (obs_done === 1'b1);
            if (prevdone) begin
                ndone++; donecyc = cyc;
                compared++;
                if (obs_busy !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL basic_busy_done: busy=%b required 1", obs_busy);
                end
            end
            @(negedge clk);
        end
        compared++;
        if (donecyc - t0 != 13) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: done after %0d cycles required 13", donecyc - t0);
        end
        compared++;
        if (ndone != 1 || acc != 4 || sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL basic_counts: done=%0d pixels=%0d left=%0d required 1 4 0",
                     ndone, acc, sb.size());
        end
    endtask

    // Sink toggles ready every 3 cycles; a stalled pixel must not change.
    task automatic test_stall();
        int ndone, acc;
        logic prevvalid, prevacc;
        logic [7:0] prevdata, exp;
        sel = 0; @(negedge clk); #1;
        push_frame(4);
        start_v = 3'b001; ready = 1'b0;
        ndone = 0; acc = 0; prevvalid = 1'b0; prevacc = 1'b0; prevdata = 8'd0;
        @(negedge clk); start_v = 3'b000;
        for (int k = 0; k < 60; k++) begin
            ready = ((k / 3) % 2) == 1;
            if (obs_valid && prevvalid && !prevacc) begin
                compared++;
                if (obs_data !== prevdata) begin
                    mismatched++;
                    $display("[TB] FAIL stall_hold: got %0h required %0h", obs_data, prevdata);
                end
            end
            if (obs_valid && ready) begin
                acc++;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL stall_extra: pixel %0h with nothing expected", obs_data);
                end else begin
                    exp = sb.pop_front();
                    if (obs_data !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL stall_data: got %0h required %0h", obs_data, exp);
                    end
                end
            end
            if (obs_done === 1'b1) ndone++;
            prevvalid = obs_valid; prevacc = obs_valid && ready; prevdata = obs_data;
            @(negedge clk);
        end
        compared++;
        if (ndone != 1 || acc != 4 || sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL stall_counts: done=%0d pixels=%0d left=%0d required 1 4 0",
                     ndone, acc, sb.size());
        end
    endtask

    // start pulsed during pixel 2 and again in the FINISH cycle: both ignored.
    task automatic test_start_while_busy();
        int ndone, acc, busyafter;
        logic seendone;
        logic [7:0] exp;
        sel = 0; @(negedge clk); #1;
        push_frame(4);
        ready = 1'b1; start_v = 3'b001;
        ndone = 0; acc = 0; busyafter = 0; seendone = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 25; k++) begin
            start_v = ((k == 8) || (obs_done === 1'b1)) ? 3'b001 : 3'b000;
            if (seendone && obs_busy) busyafter++;
            if (obs_valid && ready) begin
                acc++;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL busy_start_extra: pixel %0h with nothing expected", obs_data);
                end else begin
                    exp = sb.pop_front();
                    if (obs_data !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL busy_start_data: got %0h required %0h", obs_data, exp);
                    end
                end
            end
            if (obs_done === 1'b1) begin ndone++; seendone = 1'b1; end
            @(negedge clk);
        end
        start_v = 3'b000;
        compared++;
        if (ndone != 1 || acc != 4 || busyafter != 0) begin
            mismatched++;
            $display("[TB] FAIL busy_start_counts: done=%0d pixels=%0d busy_after=%0d required 1 4 0",
                     ndone, acc, busyafter);
        end
    endtask

    // Reset with pixel 2 pending, then a clean restart from BASE_ADDR.
    task automatic test_reset_midframe();
        int acc;
        logic hit;
        sel = 0; @(negedge clk); #1;
        ready = 1'b1; start_v = 3'b001; acc = 0; hit = 1'b0;
        @(negedge clk); start_v = 3'b000;
        for (int k = 0; k < 30 && !hit; k++) begin
            ready = (acc < 2);
            if (obs_valid && ready) acc++;
            if (obs_valid && !ready) hit = 1'b1;
            else @(negedge clk);
        end
        compared++;
        if (!hit) begin
            mismatched++;
            $display("[TB] FAIL midreset_pending: pixel 2 never pending, accepted=%0d required 2", acc);
        end
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_data !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_clear: valid=%b busy=%b done=%b data=%0h required 0 0 0 0",
                     obs_valid, obs_busy, obs_done, obs_data);
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            compared++;
            if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL midreset_quiet: done=%b busy=%b required 0 0", obs_done, obs_busy);
            end
        end
        test_basic();
    endtask

    // Latency 3 behind a 3-stage memory pipeline: 5 cycles per pixel.
    task automatic test_latency3();
        int t0, donecyc, acc, lasths;
        logic [7:0] exp;
        sel = 1; @(negedge clk); #1;
        push_frame(4);
        ready = 1'b1; start_v = 3'b010; t0 = cyc;
        acc = 0; lasths = -1; donecyc = -1;
        @(negedge clk); start_v = 3'b000;
        for (int k = 0; k < 35; k++) begin
            if (obs_valid && ready) begin
                acc++;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL lat3_extra: pixel %0h with nothing expected", obs_data);
                end else begin
                    exp = sb.pop_front();
                    if (obs_data !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL lat3_data: got %0h required %0h", obs_data, exp);
                    end
                end
                if (lasths >= 0) begin
                    compared++;
                    if (cyc - lasths != 5) begin
                        mismatched++;
                        $display("[TB] FAIL lat3_spacing: %0d cycles required 5", cyc - lasths);
                    end
                end
                lasths = cyc;
            end
            if (obs_done === 1'b1) donecyc = cyc;
            @(negedge clk);
        end
        compared++;
        if (donecyc - t0 != 21 || acc != 4) begin
            mismatched++;
            $display("[TB] FAIL lat3_frame: done after %0d cycles, %0d pixels, required 21 4",
                     donecyc - t0, acc);
        end
    endtask

    // One-word frame: done follows the only handshake by one cycle.
    task automatic test_single();
        int t0, hscyc, donecyc, acc;
        logic [7:0] exp;
        sel = 2; @(negedge clk); #1;
        push_frame(1);
        ready = 1'b1; start_v = 3'b100; t0 = cyc;
        hscyc = -100; donecyc = -1; acc = 0;
        @(negedge clk); start_v = 3'b000;
        for (int k = 0; k < 12; k++) begin
            if (obs_valid && ready) begin
                acc++; hscyc = cyc;
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL single_extra: pixel %0h with nothing expected", obs_data);
                end else begin
                    exp = sb.pop_front();
                    if (obs_data !== exp) begin
                        mismatched++;
                        $display("[TB] FAIL single_data: got %0h required %0h", obs_data, exp);
                    end
                end
            end
            if (obs_done === 1'b1) donecyc = cyc;
            @(negedge clk);
        end
        compared++;
        if (donecyc - hscyc != 1 || donecyc - t0 != 4 || acc != 1) begin
            mismatched++;
            $display("[TB] FAIL single_timing: hs->done=%0d start->done=%0d pixels=%0d required 1 4 1",
                     donecyc - hscyc, donecyc - t0, acc);
        end
    endtask

    initial begin
        reset = 1'b1; start_v = 3'b000; ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_start_while_busy();
        test_reset_midframe();
        test_latency3();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pixel_stream_reader.md
PIXEL_STREAM_READER -- requirements
Module: pixel_stream_reader

Interface
REQ-001 Parameter BASE_ADDR, default 90400: first word address of the result-pixel region in the memory controller map.
REQ-002 Parameter NUM_WORDS, default 90000: words streamed per frame; legal range 1..129600.
REQ-003 Parameter READ_LATENCY, default 1: cycles from mem_address valid to mem_rd valid; legal range 1..4.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to stream one frame.
REQ-007 mem_address  output  32  word address presented to the memory controller data port.
REQ-008 mem_rd  input  32  read data returned by the memory controller.
REQ-009 out_data  output  8  pixel byte, equal to mem_rd[7:0] of the fetched word.
REQ-010 out_valid  output  1  out_data holds a valid pixel.
REQ-011 out_ready  input  1  sink accepts out_data this cycle.
REQ-012 busy  output  1  high from start acceptance until the done cycle, inclusive.
REQ-013 done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT, SEND and FINISH.
REQ-015 IDLE: mem_address=0, out_valid=0; start=1 SHALL load word index 0 and enter ISSUE on the next edge.
REQ-016 ISSUE: mem_address SHALL equal BASE_ADDR+index; the FSM SHALL enter WAIT with the latency counter cleared.
REQ-017 WAIT: mem_address SHALL be held stable; after READ_LATENCY cycles counted from ISSUE, mem_rd[7:0] SHALL be captured into out_data and the FSM SHALL enter SEND.
REQ-018 SEND: out_valid=1 and out_data SHALL be held stable until out_valid&&out_ready is sampled high.
REQ-019 On handshake in SEND: if index==NUM_WORDS-1, enter FINISH; otherwise increment index and enter ISSUE.
REQ-020 FINISH: done=1 for exactly one cycle, then IDLE; busy SHALL drop on the following cycle.
REQ-021 start while busy SHALL be ignored; no queuing.
REQ-022 start in the FINISH cycle SHALL be ignored.
REQ-023 out_ready high outside SEND SHALL have no effect.
REQ-024 Index and address arithmetic SHALL be 32-bit unsigned. BASE_ADDR+NUM_WORDS-1 SHALL NOT exceed 219999; an elaboration-time check SHALL enforce this.
REQ-025 Throughput with out_ready held high SHALL be one pixel per (READ_LATENCY+2) cycles; a frame SHALL take exactly NUM_WORDS*(READ_LATENCY+2)+1 cycles from start to done.
REQ-026 mem_rd[31:8] SHALL be ignored.

Reset
REQ-027 With reset high at an edge, the FSM SHALL enter IDLE and index and latency counter SHALL clear.
REQ-028 The same reset SHALL drive mem_address=0, out_data=0, out_valid=0, busy=0 and done=0.
REQ-029 Reset SHALL take priority over start.
REQ-030 Reset mid-frame SHALL abort the frame without a done pulse.

Structure
REQ-031 The state enum and the constants RAM_BASE=90400 and RAM_END=220000 SHALL reside in the shared package memory_map_pkg, which the memory controller also imports.
REQ-032 The block SHALL be a single module with no sub-modules; the latency counter SHALL be at most 3 bits wide.

Verification
REQ-033 NUM_WORDS=4, memory model returns address&0xFF, out_ready=1, start pulse -> out_data sequence 0x20,0x21,0x22,0x23 (BASE 90400=0x16120); done occurs 13 cycles after start.
REQ-034 Toggle out_ready 0/1 every 3 cycles -> every pixel is accepted exactly once, out_data is stable while stalled, and there are no duplicates or gaps.
REQ-035 Pulse start again at pixel 2 of 4 -> ignored; exactly 4 pixels are sent and one done pulse occurs.
REQ-036 Assert reset while in SEND with pixel 2 pending -> next cycle out_valid=0, busy=0 and no done; a subsequent start restarts at address BASE_ADDR.
REQ-037 READ_LATENCY=3 with a 3-cycle pipelined memory model -> captured data matches the addressed word; the cycle count per pixel is 5.
REQ-038 NUM_WORDS=1 -> a single pixel is sent, and done follows its handshake by exactly 1 cycle.
